// File: rtl/psi_stream.sv
// psi_stream: private-set-intersection style combiner. A session collects up
// to N party bitmaps of B bits, counts per element how many parties hold it,
// and reports intersection, union or threshold membership plus its popcount.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, mode, thresh        session open pulse, combine mode and threshold
//   in_valid/in_ready,
//   in_data, in_last           party vector stream
//   out_valid/out_ready,
//   out_data, out_count,
//   out_err                    result bitmap, its popcount, truncation flag
//   busy                       high whenever a session is in progress
module psi_stream #(
  parameter int unsigned B = 10,
  parameter int unsigned N = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [$clog2(N+1)-1:0]        thresh,
  input  logic                          in_valid,
  input  logic [B-1:0]                  in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [B-1:0]                  out_data,
  output logic [$clog2(B+1)-1:0]        out_count,
  output logic                          out_err,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(N+1);
  localparam int unsigned PW = $clog2(B+1);

  localparam logic [1:0] MODE_UNION  = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [CW-1:0]   thresh_q;
  logic [CW-1:0]   party_q;
  logic [CW-1:0]   cnt_q [B];

  logic            accept_c;
  logic            close_c;
  logic [B-1:0]    result_c;
  logic [PW-1:0]   popcnt_c;

  // A beat closes the session when flagged last or when it is the N-th one.
  assign accept_c = in_valid && in_ready;
  assign close_c  = accept_c && (in_last || (party_q == CW'(N - 1)));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (close_c) state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-element membership decision and popcount of the result.
  always_comb begin
    result_c = '0;
    popcnt_c = '0;
    for (int unsigned k = 0; k < B; k++) begin
      case (mode_q)
        MODE_UNION:  result_c[k] = (cnt_q[k] != '0);
        MODE_THRESH: result_c[k] = (cnt_q[k] >= thresh_q);
        default:     result_c[k] = (cnt_q[k] == party_q);
      endcase
      popcnt_c = popcnt_c + PW'(result_c[k]);
    end
  end

  // State register and state-decoded handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == OUT);
      busy      <= (state_d != IDLE);
    end
  end

  // Session datapath: latch config, accumulate counts, register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      thresh_q  <= '0;
      party_q   <= '0;
      out_err   <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      for (int unsigned k = 0; k < B; k++) cnt_q[k] <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        mode_q   <= mode;
        thresh_q <= thresh;
        party_q  <= '0;
        out_err  <= 1'b0;
        for (int unsigned k = 0; k < B; k++) cnt_q[k] <= '0;
      end
      if (accept_c) begin
        for (int unsigned k = 0; k < B; k++) cnt_q[k] <= cnt_q[k] + CW'(in_data[k]);
        party_q <= party_q + CW'(1);
        // The N-th beat without in_last truncates the session.
        if (!in_last && (party_q == CW'(N - 1))) out_err <= 1'b1;
      end
      if (state_q == FINAL) begin
        out_data  <= result_c;
        out_count <= popcnt_c;
      end
    end
  end

endmodule

// File: tb/tb_psi_stream.sv
// Testbench for psi_stream: directed and random sessions, expected results
// pushed into a scoreboard at issue time and checked by a separate monitor.
module tb_psi_stream;

  localparam int unsigned B  = 10;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N+1);
  localparam int unsigned PW = $clog2(B+1);

  typedef logic [B-1:0] vq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] thresh = '0;
  logic          in_valid = 1'b0;
  logic [B-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [B-1:0]  out_data;
  logic [PW-1:0] out_count;
  logic          out_err;
  logic          out_ready = 1'b0;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beat_cyc = 0;
  bit hold_ready  = 1'b0;
  bit force_ready = 1'b0;

  logic [B-1:0] exp_d[$];
  int           exp_c[$];
  bit           exp_e[$];

  psi_stream #(.B(B), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .thresh(thresh),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_err(out_err), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random backpressure unless held low or forced high.
  always @(posedge clk) begin
    #1;
    out_ready = hold_ready ? 1'b0 : (force_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
  end

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Reference: per-element party counts compared against the mode's rule.
  task automatic model(input int md, input int th, input vq_t v, input bit last_flag,
                       output logic [B-1:0] d, output int c, output bit e);
    d = '0;
    for (int k = 0; k < B; k++) begin
      int n;
      n = 0;
      foreach (v[i]) n += int'(v[i][k]);
      case (md)
        1:       d[k] = (n > 0);
        2:       d[k] = (n >= th);
        default: d[k] = (n == v.size());
      endcase
    end
    c = $countones(d);
    e = (v.size() == N) && !last_flag;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int md, input int th);
    start = 1'b1;
    mode = 2'(md);
    thresh = CW'(th);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 2'($urandom);
    thresh = CW'($urandom);
  endtask

  task automatic send_beats(input vq_t v, input bit last_flag, input bit gaps);
    foreach (v[i]) begin
      int n;
      bit hs;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data = B'($urandom);
          in_last = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data = v[i];
      in_last = last_flag && (i == v.size() - 1);
      n = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin
        @(negedge clk);
        hs = in_ready;
        if (hs) beat_cyc = cyc;
        @(posedge clk);
        #1;
        n++;
      end
      if (!hs) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic push_exp(input logic [B-1:0] d, input int c, input bit e);
    exp_d.push_back(d);
    exp_c.push_back(c);
    exp_e.push_back(e);
  endtask

  task automatic session_model(input int md, input int th, input vq_t v, input bit last_flag);
    logic [B-1:0] d;
    int c;
    bit e;
    wait_idle();
    model(md, th, v, last_flag, d, c, e);
    push_exp(d, c, e);
    do_start(md, th);
    send_beats(v, last_flag, 1'b1);
  endtask

  task automatic session_exp(input int md, input int th, input vq_t v, input bit last_flag,
                             input logic [B-1:0] d, input int c, input bit e);
    wait_idle();
    push_exp(d, c, e);
    do_start(md, th);
    send_beats(v, last_flag, 1'b0);
  endtask

  // Monitor: pop on each new result, then hold outputs stable until taken.
  initial begin
    bit prev_v, drop_pending;
    logic [B-1:0] hd;
    logic [PW-1:0] hc;
    logic he;
    prev_v = 1'b0;
    drop_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        drop_pending = 1'b0;
      end else begin
        if (drop_pending) begin
          chk("out_valid_drop", out_valid, 0);
          chk("idle_after_take", busy, 0);
          drop_pending = 1'b0;
        end
        if (out_valid) begin
          if (!prev_v) begin
            chk("latency", cyc - beat_cyc, 2);
            if (exp_d.size() == 0) begin
              chk("unexpected_output", 1, 0);
            end else begin
              chk("out_data", out_data, exp_d.pop_front());
              chk("out_count", out_count, exp_c.pop_front());
              chk("out_err", out_err, exp_e.pop_front());
            end
          end else begin
            chk("hold_data", out_data, hd);
            chk("hold_count", out_count, hc);
            chk("hold_err", out_err, he);
          end
          hd = out_data;
          hc = out_count;
          he = out_err;
          if (out_ready) begin
            drop_pending = 1'b1;
            prev_v = 1'b0;
          end else begin
            prev_v = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    vq_t v;
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Intersection.
    v = {10'h3FF, 10'h2F5, 10'h0F7, 10'h0B5};
    session_exp(0, 0, v, 1'b1, 10'h0B5, 5, 1'b0);
    // Threshold 2.
    v = {10'h003, 10'h006, 10'h00C};
    session_exp(2, 2, v, 1'b1, 10'h006, 2, 1'b0);
    // Threshold boundaries.
    v = {10'h000, 10'h001, 10'h100};
    session_exp(2, 0, v, 1'b1, 10'h3FF, 10, 1'b0);
    v = {10'h3FF, 10'h3FF, 10'h3FF};
    session_exp(2, 4, v, 1'b1, 10'h000, 0, 1'b0);
    // Single beat, union and intersection (mode 3 aliases intersection).
    v = {10'h2A7};
    session_exp(1, 0, v, 1'b1, 10'h2A7, 6, 1'b0);
    session_exp(3, 0, v, 1'b1, 10'h2A7, 6, 1'b0);

    // Truncation: 5th in_valid is never accepted.
    v = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    session_exp(0, 0, v, 1'b0, 10'h3FF, 10, 1'b1);
    in_valid = 1'b1;
    in_data = 10'h3FF;
    repeat (3) begin
      @(negedge clk);
      chk("no_5th_accept", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Backpressure with a start pulse during OUT.
    hold_ready = 1'b1;
    v = {10'h001, 10'h010};
    session_exp(1, 0, v, 1'b1, 10'h011, 2, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("bp_out_valid_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    mode = 2'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    force_ready = 1'b1;
    hold_ready = 1'b0;
    wait_idle();
    force_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("start_ignored_in_out", busy, 0);
    end
    @(posedge clk);
    #1;

    // Mid-session reset aborts without output.
    wait_idle();
    do_start(0, 0);
    v = {10'h3FF, 10'h155};
    send_beats(v, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = {10'h155};
    session_exp(0, 0, v, 1'b1, 10'h155, 5, 1'b0);

    // Random sessions against the model.
    for (int s = 0; s < 40; s++) begin
      int nb;
      bit lf;
      v = {};
      nb = $urandom_range(1, N);
      for (int i = 0; i < nb; i++) v.push_back(B'($urandom));
      lf = (nb < N) ? 1'b1 : 1'($urandom);
      session_model($urandom_range(0, 3), $urandom_range(0, N + 1), v, lf);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
